// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard unit: forwarding, stalls, flushes, memory wait/timeout
//
// Purpose:
//   Resolves data hazards for the 5-stage MIPS pipeline.
//   - RAW hazards are resolved by forwarding.
//   - Load-use and branch/jr compare hazards insert a stall plus an execute bubble.
//   - The whole pipeline freezes while data memory is not ready.
//   - A sticky mem_error is latched if memory stays not-ready for more than MEM_TIMEOUT wait cycles.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   Defined: builds the saturating performance counters.
//   Undefined: the counter ports are tied to zero.
//
// Ports:
//   clk, reset (sync, active-low)
//   rs/rt_decode, rs/rt_execute               source registers
//   write_reg_*/reg_write_* (ex/mem/wb)       destination register and write enable per stage
//   mem_to_reg_execute/memory                 bit 0 marks a load
//   branch_decode, branch_not_equal_decode,
//   jump_pc_decode                            decode-stage compare or jr
//   mem_access_memory, mem_ready              data memory handshake
//   stall_*, flush_execute, flush_writeback   pipeline register controls
//   forward_a/b_decode                        decode compare bypass from memory stage
//   forward_a/b_execute                       ALU operand select (00 rf, 01 wb, 10 mem)
//   mem_error                                 sticky memory timeout flag
//   stall_cycles_count, flush_count,
//   mem_wait_count                            performance counters

module hazard_unit #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs_decode,
   input  logic [4:0]       rt_decode,
   input  logic [4:0]       rs_execute,
   input  logic [4:0]       rt_execute,
   input  logic [4:0]       write_reg_execute,
   input  logic [4:0]       write_reg_memory,
   input  logic [4:0]       write_reg_writeback,
   input  logic             reg_write_execute,
   input  logic             reg_write_memory,
   input  logic             reg_write_writeback,
   input  logic [1:0]       mem_to_reg_execute,
   input  logic [1:0]       mem_to_reg_memory,
   input  logic             branch_decode,
   input  logic             branch_not_equal_decode,
   input  logic             jump_pc_decode,
   input  logic             mem_access_memory,
   input  logic             mem_ready,
   output logic             stall_fetch,
   output logic             stall_decode,
   output logic             stall_execute,
   output logic             stall_memory,
   output logic             flush_execute,
   output logic             flush_writeback,
   output logic             forward_a_decode,
   output logic             forward_b_decode,
   output logic [1:0]       forward_a_execute,
   output logic [1:0]       forward_b_execute,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_cycles_count,
   output logic [CNT_W-1:0] flush_count,
   output logic [CNT_W-1:0] mem_wait_count
);

   localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ERROR = 2'd2
   } mem_state_t;

   mem_state_t        state, state_next;
   logic [WCNT_W-1:0] wait_cnt, wait_cnt_next;
   logic              mem_error_q, mem_error_next;

   // Only bit 0 of the mem_to_reg fields identifies a load.
   logic unused_mem_to_reg_hi;
   assign unused_mem_to_reg_hi = mem_to_reg_execute[1] ^ mem_to_reg_memory[1];

   // A stage hits r when it writes a non-zero register equal to r; $0 never hits.
   function automatic logic hits(input logic rw, input logic [4:0] wr, input logic [4:0] r);
      return rw && (wr != 5'd0) && (wr == r);
   endfunction

   logic ex_hit_rs_d, ex_hit_rt_d, mem_hit_rs_d, mem_hit_rt_d;
   logic mem_hit_rs_e, mem_hit_rt_e, wb_hit_rs_e, wb_hit_rt_e;
   logic lw_stall, br_stall, jr_stall, mem_stall;

   assign ex_hit_rs_d  = hits(reg_write_execute,   write_reg_execute,   rs_decode);
   assign ex_hit_rt_d  = hits(reg_write_execute,   write_reg_execute,   rt_decode);
   assign mem_hit_rs_d = hits(reg_write_memory,    write_reg_memory,    rs_decode);
   assign mem_hit_rt_d = hits(reg_write_memory,    write_reg_memory,    rt_decode);
   assign mem_hit_rs_e = hits(reg_write_memory,    write_reg_memory,    rs_execute);
   assign mem_hit_rt_e = hits(reg_write_memory,    write_reg_memory,    rt_execute);
   assign wb_hit_rs_e  = hits(reg_write_writeback, write_reg_writeback, rs_execute);
   assign wb_hit_rt_e  = hits(reg_write_writeback, write_reg_writeback, rt_execute);

   assign lw_stall = mem_to_reg_execute[0] && (ex_hit_rs_d || ex_hit_rt_d);

   // The decode compare cannot use a value still in execute, nor a load result still in memory.
   assign br_stall = (branch_decode || branch_not_equal_decode) &&
                     ((ex_hit_rs_d || ex_hit_rt_d) ||
                      (mem_to_reg_memory[0] && (mem_hit_rs_d || mem_hit_rt_d)));

   assign jr_stall = jump_pc_decode &&
                     (ex_hit_rs_d || (mem_to_reg_memory[0] && mem_hit_rs_d));

   assign mem_stall = (state == ST_ERROR) || (mem_access_memory && !mem_ready);

   // Memory wait / timeout FSM
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         wait_cnt    <= '0;
         mem_error_q <= 1'b0;
      end else begin
         state       <= state_next;
         wait_cnt    <= wait_cnt_next;
         mem_error_q <= mem_error_next;
      end
   end

   always_comb begin
      state_next     = state;
      wait_cnt_next  = wait_cnt;
      mem_error_next = mem_error_q;
      unique case (state)
         ST_IDLE: begin
            if (mem_access_memory && !mem_ready) begin
               state_next    = ST_WAIT;
               wait_cnt_next = WCNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (mem_ready || !mem_access_memory) begin
               state_next    = ST_IDLE;
               wait_cnt_next = '0;
            end else if (wait_cnt == WCNT_W'(MEM_TIMEOUT)) begin
               state_next     = ST_ERROR;
               mem_error_next = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt + WCNT_W'(1);
            end
         end
         ST_ERROR: begin
            state_next = ST_ERROR;
         end
         default: begin
            state_next    = ST_IDLE;
            wait_cnt_next = '0;
         end
      endcase
   end

   assign mem_error = mem_error_q;

   // Output resolution; everything is held at zero while reset is asserted.
   always_comb begin
      stall_fetch       = 1'b0;
      stall_decode      = 1'b0;
      stall_execute     = 1'b0;
      stall_memory      = 1'b0;
      flush_execute     = 1'b0;
      flush_writeback   = 1'b0;
      forward_a_decode  = 1'b0;
      forward_b_decode  = 1'b0;
      forward_a_execute = 2'b00;
      forward_b_execute = 2'b00;
      if (reset) begin
         forward_a_decode = mem_hit_rs_d;
         forward_b_decode = mem_hit_rt_d;

         if (mem_hit_rs_e)     forward_a_execute = 2'b10;
         else if (wb_hit_rs_e) forward_a_execute = 2'b01;

         if (mem_hit_rt_e)     forward_b_execute = 2'b10;
         else if (wb_hit_rt_e) forward_b_execute = 2'b01;

         // A frozen pipeline must not also bubble execute, or the held instruction is lost.
         if (mem_stall) begin
            stall_fetch     = 1'b1;
            stall_decode    = 1'b1;
            stall_execute   = 1'b1;
            stall_memory    = 1'b1;
            flush_writeback = 1'b1;
         end else if (lw_stall || br_stall || jr_stall) begin
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            flush_execute = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         if (stall_fetch && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_execute && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         if (mem_stall && (state != ST_ERROR) && (wait_cnt_q != '1))
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cycles_count = stall_cnt_q;
   assign flush_count        = flush_cnt_q;
   assign mem_wait_count     = wait_cnt_q;
`else
   assign stall_cycles_count = '0;
   assign flush_count        = '0;
   assign mem_wait_count     = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking scoreboard bench for hazard_unit

module tb_hazard_unit;

   localparam int CNT_W = 32;

   logic clk = 1'b0;
   logic reset;
   logic [4:0] rs_decode, rt_decode, rs_execute, rt_execute;
   logic [4:0] write_reg_execute, write_reg_memory, write_reg_writeback;
   logic reg_write_execute, reg_write_memory, reg_write_writeback;
   logic [1:0] mem_to_reg_execute, mem_to_reg_memory;
   logic branch_decode, branch_not_equal_decode, jump_pc_decode;
   logic mem_access_memory, mem_ready;
   logic stall_fetch, stall_decode, stall_execute, stall_memory;
   logic flush_execute, flush_writeback, forward_a_decode, forward_b_decode;
   logic [1:0] forward_a_execute, forward_b_execute;
   logic mem_error;
   logic [CNT_W-1:0] stall_cycles_count, flush_count, mem_wait_count;

   int total = 0;
   int passed = 0;
   logic [12:0] exp_q[$];
   logic [12:0] e, got;

   always #5 clk = ~clk;

   hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .rs_decode(rs_decode), .rt_decode(rt_decode),
      .rs_execute(rs_execute), .rt_execute(rt_execute),
      .write_reg_execute(write_reg_execute), .write_reg_memory(write_reg_memory),
      .write_reg_writeback(write_reg_writeback),
      .reg_write_execute(reg_write_execute), .reg_write_memory(reg_write_memory),
      .reg_write_writeback(reg_write_writeback),
      .mem_to_reg_execute(mem_to_reg_execute), .mem_to_reg_memory(mem_to_reg_memory),
      .branch_decode(branch_decode), .branch_not_equal_decode(branch_not_equal_decode),
      .jump_pc_decode(jump_pc_decode),
      .mem_access_memory(mem_access_memory), .mem_ready(mem_ready),
      .stall_fetch(stall_fetch), .stall_decode(stall_decode),
      .stall_execute(stall_execute), .stall_memory(stall_memory),
      .flush_execute(flush_execute), .flush_writeback(flush_writeback),
      .forward_a_decode(forward_a_decode), .forward_b_decode(forward_b_decode),
      .forward_a_execute(forward_a_execute), .forward_b_execute(forward_b_execute),
      .mem_error(mem_error),
      .stall_cycles_count(stall_cycles_count), .flush_count(flush_count),
      .mem_wait_count(mem_wait_count)
   );

   // {stall f,d,e,m} {flush e,wb} {fwd dec a,b} {fwd ex a} {fwd ex b} {mem_error}
   function automatic logic [12:0] mk(input logic [3:0] st, input logic [1:0] fl,
                                      input logic [1:0] fd, input logic [1:0] fa,
                                      input logic [1:0] fb, input logic me);
      return {st, fl, fd, fa, fb, me};
   endfunction

   function automatic logic [12:0] obs();
      return {stall_fetch, stall_decode, stall_execute, stall_memory,
              flush_execute, flush_writeback, forward_a_decode, forward_b_decode,
              forward_a_execute, forward_b_execute, mem_error};
   endfunction

   localparam logic [3:0] ST_ALL = 4'b1111;
   localparam logic [3:0] ST_FD  = 4'b1100;

   task automatic clear_inputs();
      reset = 1'b1;
      rs_decode = 0; rt_decode = 0; rs_execute = 0; rt_execute = 0;
      write_reg_execute = 0; write_reg_memory = 0; write_reg_writeback = 0;
      reg_write_execute = 0; reg_write_memory = 0; reg_write_writeback = 0;
      mem_to_reg_execute = 0; mem_to_reg_memory = 0;
      branch_decode = 0; branch_not_equal_decode = 0; jump_pc_decode = 0;
      mem_access_memory = 0; mem_ready = 0;
   endtask

   task automatic test_reset();
      // hazardous inputs while in reset: everything must stay low
      mem_to_reg_execute = 2'b01; reg_write_execute = 1; write_reg_execute = 8; rt_decode = 8;
      mem_access_memory = 1; mem_ready = 0;
      write_reg_memory = 5; reg_write_memory = 1; rs_execute = 5; rs_decode = 5;
      reset = 0;
      exp_q.push_back(mk(4'b0, 2'b0, 2'b0, 2'b0, 2'b0, 1'b0));
      #2 e = exp_q.pop_front(); got = obs(); total++;
      if (got !== e) $display("FAIL reset_outputs got=%b exp=%b", got, e); else passed++;
      @(negedge clk);
      total++;
      if (stall_cycles_count !== '0 || flush_count !== '0 || mem_wait_count !== '0)
         $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0",
                  stall_cycles_count, flush_count, mem_wait_count);
      else passed++;
      clear_inputs();
   endtask

   task automatic test_forward_execute();
      for (int s = 0; s < 5; s++) begin
         clear_inputs();
         case (s)
            0: begin write_reg_memory = 5; reg_write_memory = 1; write_reg_writeback = 5;
                     reg_write_writeback = 1; rs_execute = 5;
                     exp_q.push_back(mk(0, 0, 0, 2'b10, 2'b00, 0)); end
            1: begin write_reg_memory = 5; reg_write_memory = 0; write_reg_writeback = 5;
                     reg_write_writeback = 1; rs_execute = 5;
                     exp_q.push_back(mk(0, 0, 0, 2'b01, 2'b00, 0)); end
            2: begin write_reg_memory = 0; reg_write_memory = 1; write_reg_writeback = 0;
                     reg_write_writeback = 1; rs_execute = 0; rt_execute = 0;
                     exp_q.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0)); end
            3: begin write_reg_memory = 3; reg_write_memory = 1; write_reg_writeback = 3;
                     reg_write_writeback = 1; rt_execute = 3; rs_execute = 7;
                     exp_q.push_back(mk(0, 0, 0, 2'b00, 2'b10, 0)); end
            default: begin write_reg_memory = 4; reg_write_memory = 1; write_reg_writeback = 12;
                     reg_write_writeback = 1; rs_execute = 4; rt_execute = 12;
                     exp_q.push_back(mk(0, 0, 0, 2'b10, 2'b01, 0)); end
         endcase
         #2 e = exp_q.pop_front(); got = obs(); total++;
         if (got !== e) $display("FAIL fwd_ex_step%0d got=%b exp=%b", s, got, e); else passed++;
         @(negedge clk);
      end
      clear_inputs();
   endtask

   task automatic test_load_use();
      mem_to_reg_execute = 2'b01; reg_write_execute = 1; write_reg_execute = 8; rt_decode = 8;
      exp_q.push_back(mk(ST_FD, 2'b10, 0, 0, 0, 0));
      #2 e = exp_q.pop_front(); got = obs(); total++;
      if (got !== e) $display("FAIL load_use_stall got=%b exp=%b", got, e); else passed++;
      @(negedge clk);
      mem_to_reg_execute = 2'b00; reg_write_execute = 0; write_reg_execute = 0;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
      #2 e = exp_q.pop_front(); got = obs(); total++;
      if (got !== e) $display("FAIL load_use_bubble got=%b exp=%b", got, e); else passed++;
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_branch();
      for (int s = 0; s < 5; s++) begin
         clear_inputs();
         case (s)
            0: begin branch_decode = 1; rs_decode = 9; mem_to_reg_memory = 2'b01;
                     reg_write_memory = 1; write_reg_memory = 9;
                     exp_q.push_back(mk(ST_FD, 2'b10, 2'b10, 0, 0, 0)); end
            1: begin branch_decode = 1; rs_decode = 9; mem_to_reg_memory = 2'b00;
                     reg_write_memory = 1; write_reg_memory = 9;
                     exp_q.push_back(mk(0, 0, 2'b10, 0, 0, 0)); end
            2: begin branch_not_equal_decode = 1; rt_decode = 6; reg_write_execute = 1;
                     write_reg_execute = 6;
                     exp_q.push_back(mk(ST_FD, 2'b10, 0, 0, 0, 0)); end
            3: begin jump_pc_decode = 1; rs_decode = 2; rt_decode = 6; reg_write_execute = 1;
                     write_reg_execute = 6;
                     exp_q.push_back(mk(0, 0, 0, 0, 0, 0)); end
            default: begin jump_pc_decode = 1; rs_decode = 6; reg_write_execute = 1;
                     write_reg_execute = 6;
                     exp_q.push_back(mk(ST_FD, 2'b10, 0, 0, 0, 0)); end
         endcase
         #2 e = exp_q.pop_front(); got = obs(); total++;
         if (got !== e) $display("FAIL branch_step%0d got=%b exp=%b", s, got, e); else passed++;
         @(negedge clk);
      end
      clear_inputs();
   endtask

   task automatic test_mem_wait();
      for (int s = 0; s < 5; s++) begin
         mem_access_memory = (s < 4);
         mem_ready = (s == 3);
         if (s < 3) exp_q.push_back(mk(ST_ALL, 2'b01, 0, 0, 0, 0));
         else       exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
         #2 e = exp_q.pop_front(); got = obs(); total++;
         if (got !== e) $display("FAIL mem_wait_cyc%0d got=%b exp=%b", s, got, e); else passed++;
         @(negedge clk);
      end
      // ready in the same cycle the access starts: no stall at all
      mem_access_memory = 1; mem_ready = 1;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
      #2 e = exp_q.pop_front(); got = obs(); total++;
      if (got !== e) $display("FAIL mem_ready_same_cycle got=%b exp=%b", got, e); else passed++;
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_priority();
      reset = 0;
      @(negedge clk);
      reset = 1;
      for (int s = 0; s < 5; s++) begin
         clear_inputs();
         if (s < 4) begin
            mem_to_reg_execute = 2'b01; reg_write_execute = 1; write_reg_execute = 8;
            rt_decode = 8; mem_access_memory = 1; mem_ready = (s == 3);
         end
         if (s < 3)       exp_q.push_back(mk(ST_ALL, 2'b01, 0, 0, 0, 0));
         else if (s == 3) exp_q.push_back(mk(ST_FD, 2'b10, 0, 0, 0, 0));
         else             exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
         #2 e = exp_q.pop_front(); got = obs(); total++;
         if (got !== e) $display("FAIL priority_cyc%0d got=%b exp=%b", s, got, e); else passed++;
         if (s == 4) begin
`ifdef HAZARD_PERF_CNT_EN
            total++;
            if (mem_wait_count !== 32'd3) $display("FAIL perf_mem_wait got=%0d exp=3", mem_wait_count);
            else passed++;
            total++;
            if (stall_cycles_count !== 32'd4) $display("FAIL perf_stall got=%0d exp=4", stall_cycles_count);
            else passed++;
            total++;
            if (flush_count !== 32'd1) $display("FAIL perf_flush got=%0d exp=1", flush_count);
            else passed++;
`else
            total++;
            if (mem_wait_count !== '0 || stall_cycles_count !== '0 || flush_count !== '0)
               $display("FAIL perf_tied_zero got=%0d/%0d/%0d exp=0/0/0",
                        stall_cycles_count, flush_count, mem_wait_count);
            else passed++;
`endif
         end
         @(negedge clk);
      end
      clear_inputs();
   endtask

   task automatic test_timeout();
      // MEM_TIMEOUT = 4: error latches on the 5th wait edge
      for (int s = 0; s < 8; s++) begin
         mem_access_memory = (s < 7);
         mem_ready = (s == 6);
         exp_q.push_back(mk(ST_ALL, 2'b01, 0, 0, 0, (s >= 5)));
         #2 e = exp_q.pop_front(); got = obs(); total++;
         if (got !== e) $display("FAIL timeout_cyc%0d got=%b exp=%b", s, got, e); else passed++;
         @(negedge clk);
      end
      reset = 0;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
      #2 e = exp_q.pop_front(); got = obs(); total++;
      if (got !== e) $display("FAIL timeout_in_reset got=%b exp=%b", got, e); else passed++;
      @(negedge clk);
      reset = 1; mem_access_memory = 0;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
      #2 e = exp_q.pop_front(); got = obs(); total++;
      if (got !== e) $display("FAIL timeout_cleared got=%b exp=%b", got, e); else passed++;
      @(negedge clk);
      mem_access_memory = 1; mem_ready = 1;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
      #2 e = exp_q.pop_front(); got = obs(); total++;
      if (got !== e) $display("FAIL timeout_back_idle got=%b exp=%b", got, e); else passed++;
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_timeout sim time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      reset = 0;
      @(negedge clk);
      @(negedge clk);
      test_reset();
      @(negedge clk);
      test_forward_execute();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_priority();
      test_timeout();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
